// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller for the dual-issue front end.
// It sequences a 64-bit memory with one-cycle read latency, clears the memory
// output on redirects, and presents fetched instruction pairs to decode. The
// pairs pass through a 2-entry buffer that uses a valid/ready handshake.
module fetch_ctrl #(
  parameter logic [9:0] RESET_PC = 10'h000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [9:0]  redirect_pc_i,
  output logic        imem_re_o,
  output logic        imem_ssr_o,
  output logic [9:0]  imem_addr_o,
  input  logic [63:0] imem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [9:0]  out_pc_o,
  output logic [31:0] out_inst0_o,
  output logic [31:0] out_inst1_o
);

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  // One buffered fetch packet.
  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
  } entry_t;

  state_t     state_q, state_d;
  logic [9:0] fetch_pc_q, fetch_pc_d;
  logic [9:0] tag_pc_q, tag_pc_d;
  logic       inflight_q, inflight_d;
  logic [1:0] count_q, count_d;
  // head_q is always the entry shown to decode; tail_q is the second entry.
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;
  logic [1:0] push_slot;
  entry_t     resp;

  // Only the word-aligned part of a redirect target is meaningful.
  logic       unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Handshake, response capture and the issue decision.
  always_comb begin
    pop       = (count_q != 2'd0) && out_ready_i;
    push      = inflight_q;
    resp      = '{pc: tag_pc_q, inst0: imem_data_i[63:32], inst1: imem_data_i[31:0]};
    // A pop requires count_q > 0, so this subtraction can never underflow.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == ST_FETCH) && (occupancy < 3'd2);
    push_slot = count_q - {1'b0, pop};
  end

  // Next-state logic for the FSM, the fetch PC and the buffer, plus the memory controls.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    tag_pc_d    = tag_pc_q;
    inflight_d  = 1'b0;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    imem_re_o   = 1'b0;
    imem_ssr_o  = 1'b0;
    imem_addr_o = fetch_pc_q;

    case (state_q)
      ST_FLUSH: begin
        // Clear the memory output register so no stale word is seen later.
        imem_re_o  = 1'b1;
        imem_ssr_o = 1'b1;
        count_d    = 2'd0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        imem_re_o = issue;
        if (issue) begin
          fetch_pc_d = fetch_pc_q + 10'd8;
          tag_pc_d   = fetch_pc_q;
          inflight_d = 1'b1;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
          head_d = tail_q;
        end
        // After an optional pop, the response goes into the first free slot.
        if (push) begin
          if (push_slot == 2'd0) begin
            head_d = resp;
          end else begin
            tail_d = resp;
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase

    // A redirect overrides everything: it drops the buffer and any response in flight.
    if (redirect_i) begin
      state_d    = ST_FLUSH;
      fetch_pc_d = {redirect_pc_i[9:2], 2'b00};
      count_d    = 2'd0;
      inflight_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (reset_i) begin
      state_q    <= ST_FLUSH;
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= 10'h000;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      // NOTE: the buffer storage is reset as well, because its head drives the packet outputs, which must read zero after reset.
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_pc_o    = head_q.pc;
  assign out_inst0_o = head_q.inst0;
  assign out_inst1_o = head_q.inst1;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: a self-checking bench for fetch_ctrl. A word-addressed memory
// model serves the reads. A packet-level reference model predicts the packet
// that decode should see next. It also checks redirect latency and the
// stability of packets under backpressure.
module tb_fetch_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        redirect_i;
  logic [9:0]  redirect_pc_i;
  logic        imem_re_o;
  logic        imem_ssr_o;
  logic [9:0]  imem_addr_o;
  logic [63:0] imem_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [9:0]  out_pc_o;
  logic [31:0] out_inst0_o;
  logic [31:0] out_inst1_o;

  fetch_ctrl #(.RESET_PC(10'h000)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_re_o     (imem_re_o),
    .imem_ssr_o    (imem_ssr_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst0_o   (out_inst0_o),
    .out_inst1_o   (out_inst1_o)
  );

  always #5 clock_i = ~clock_i;

  // Instruction memory seen as 256 32-bit words.
  logic [31:0] mem32 [256];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [9:0] a);
    return mem32[a[9:2]];
  endfunction

  // Memory model: one-cycle read latency, and a synchronous clear when ssr is set.
  always @(posedge clock_i) begin
    if (imem_re_o === 1'b1)
      imem_data_i <= imem_ssr_o ? 64'h0 : {word_at(imem_addr_o), word_at(imem_addr_o + 10'd4)};
  end

  // Packet-level reference model, sampled on the falling edge.
  bit          mon_en   = 1'b0;
  bit          pending  = 1'b0;
  int          age      = 0;
  bit          held     = 1'b0;
  logic [73:0] held_pkt = '0;
  logic [9:0]  exp_pc   = '0;

  always @(negedge clock_i) begin
    if (reset_i === 1'b1) mon_en = 1'b1;
    if (mon_en) begin
      // After a restart, the first packet must appear exactly 4 cycles later.
      if (pending) begin
        age++;
        if (age < 4) check("restart_gap", out_valid_o, 1'b0);
        else begin
          check("restart_first", out_valid_o, 1'b1);
          pending = 1'b0;
        end
      end
      if (held) begin
        check("hold_valid", out_valid_o, 1'b1);
        check("hold_pkt", {out_pc_o, out_inst0_o, out_inst1_o}, held_pkt);
      end
      if (!pending && out_valid_o) begin
        check("pkt_pc", out_pc_o, exp_pc);
        check("pkt_inst", {out_inst0_o, out_inst1_o}, {word_at(exp_pc), word_at(exp_pc + 10'd4)});
      end
      held     = out_valid_o && !out_ready_i && !redirect_i && !reset_i;
      held_pkt = {out_pc_o, out_inst0_o, out_inst1_o};
      if (reset_i || redirect_i) begin
        exp_pc  = reset_i ? 10'h000 : {redirect_pc_i[9:2], 2'b00};
        pending = 1'b1;
        age     = 0;
      end else if (out_valid_o && out_ready_i) begin
        exp_pc = exp_pc + 10'd8;
      end
    end
  end

  // The redirect lands on a live handshake and response; three bubbles follow, then packets from the target.
  task automatic redirect_check(input logic [9:0] pc);
    logic [9:0] p;
    p = {pc[9:2], 2'b00};
    @(posedge clock_i) #1;
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    @(negedge clock_i) check("rd_hs_valid", out_valid_o, 1'b1);
    @(posedge clock_i) #1;
    redirect_i = 1'b0;
    repeat (3) begin
      @(negedge clock_i) check("rd_gap", out_valid_o, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_i);
      check("rd_valid", out_valid_o, 1'b1);
      check("rd_pc", out_pc_o, p);
      p = p + 10'd8;
    end
  endtask

  initial begin
    int issues;
    logic [9:0] p;
    for (int i = 0; i < 256; i++) mem32[i] = $urandom;
    reset_i       = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = 10'h000;
    out_ready_i   = 1'b0;
    repeat (3) @(posedge clock_i);

    // Values while reset is held.
    @(negedge clock_i);
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_pc", out_pc_o, 10'h000);
    check("rst_inst0", out_inst0_o, 32'h0);
    check("rst_inst1", out_inst1_o, 32'h0);
    check("rst_re", imem_re_o, 1'b1);
    check("rst_ssr", imem_ssr_o, 1'b1);
    check("rst_addr", imem_addr_o, 10'h000);

    // Backpressure right after reset: exactly two reads fill the buffer.
    @(posedge clock_i) #1;
    reset_i = 1'b0;
    issues  = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_i);
      if (imem_re_o && !imem_ssr_o) issues++;
    end
    check("bp_issues", issues, 2);
    check("bp_head", out_pc_o, 10'h000);

    // Release: one packet per cycle, with no gaps.
    @(posedge clock_i) #1;
    out_ready_i = 1'b1;
    repeat (12) begin
      @(negedge clock_i) check("stream_valid", out_valid_o, 1'b1);
    end

    redirect_check(10'h1A6);
    redirect_check(10'h3F0);

    // Back-to-back redirects: only the second target may appear.
    @(posedge clock_i) #1;
    redirect_i    = 1'b1;
    redirect_pc_i = 10'h040;
    @(posedge clock_i) #1;
    redirect_pc_i = 10'h100;
    @(negedge clock_i) check("b2b_flush_valid", out_valid_o, 1'b0);
    @(posedge clock_i) #1;
    redirect_i = 1'b0;
    repeat (3) begin
      @(negedge clock_i) check("b2b_gap", out_valid_o, 1'b0);
    end
    p = 10'h100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_i);
      check("b2b_valid", out_valid_o, 1'b1);
      check("b2b_pc", out_pc_o, p);
      p = p + 10'd8;
    end

    // Random ready and redirect traffic, checked by the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock_i) #1;
      out_ready_i   = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 31) == 0);
      redirect_pc_i = 10'($urandom_range(0, 1023));
    end
    @(posedge clock_i) #1;
    redirect_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (10) @(posedge clock_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the 64-bit, one-cycle-latency instruction memory for the dual-issue front end. Holds the fetch PC, issues read requests, applies the memory's synchronous output clear on pipeline redirects, and presents each returned pair of 32-bit instructions to decode through a 2-entry buffer with a valid/ready handshake. Sits between the branch/redirect logic and the decode stage.

## Interface
- RESET_PC, 10'h000, byte address fetched first after reset (bits [1:0] must be 0)
- clock_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- redirect_i  in  1  flush pipeline, restart fetch at redirect_pc_i
- redirect_pc_i  in  10  redirect byte address; bits [1:0] ignored, treated as 0
- imem_re_o  out  1  memory read enable
- imem_ssr_o  out  1  memory synchronous output clear, only meaningful with imem_re_o
- imem_addr_o  out  10  memory byte address
- imem_data_i  in  64  memory read data, valid the cycle after a read; [63:32] = word at address, [31:0] = word at address+4
- out_valid_o  out  1  fetch packet available
- out_ready_i  in  1  decode accepts packet; transfer when out_valid_o && out_ready_i
- out_pc_o  out  10  byte address of out_inst0_o
- out_inst0_o  out  32  instruction at out_pc_o
- out_inst1_o  out  32  instruction at out_pc_o+4

## Operation
- States: FLUSH, FETCH.
- FLUSH (one cycle): imem_re_o=1, imem_ssr_o=1, imem_addr_o=fetch_pc. Buffer emptied, in-flight flag cleared. Next state FETCH.
- FETCH: issue a read (imem_re_o=1, imem_ssr_o=0, imem_addr_o=fetch_pc) when count + inflight − pop < 2, where count = buffered entries (0..2), inflight = read issued last cycle, and pop = out_valid_o && out_ready_i. On issue: fetch_pc <= fetch_pc + 8, modulo 1024 (wraps 10'h3F8 -> 10'h000); inflight <= 1 with tag pc. No issue: imem_re_o=0, fetch_pc held, inflight <= 0.
- Response: if inflight, the cycle's imem_data_i with tagged pc is written to the buffer tail at the end of that cycle.
- Buffer: 2-entry FIFO of {pc, inst0, inst1}. Outputs come from the head entry, registered, with no bypass from imem_data_i. Simultaneous push and pop are allowed at any count. The issue rule guarantees no overflow.
- redirect_i in any state, taking priority over everything: next state FLUSH. fetch_pc <= {redirect_pc_i[9:2], 2'b00}. Buffer cleared. Response arriving that cycle dropped. A pop presented that same cycle is not a transfer: out_valid_o stays as displayed, but the entry is discarded with the flush.
- redirect_i during FLUSH: new PC loaded, FLUSH repeats one more cycle. The last redirect wins.
- reset_i: state <= FLUSH, fetch_pc <= RESET_PC, count <= 0, inflight <= 0.

## Timing
- Reset values (cycle after reset_i high): out_valid_o=0, out_pc_o=0, out_inst0_o=0, out_inst1_o=0, imem_re_o=1, imem_ssr_o=1, imem_addr_o=RESET_PC.
- imem_* outputs are combinational from state, fetch_pc, count, inflight and out_ready_i.
- Reset release or redirect at cycle t:
  - t+1 FLUSH
  - t+2 first issue
  - t+3 data returns
  - t+4 out_valid_o=1
- Reset deasserted at cycle 0 (FLUSH): issue at 0+1, out_valid_o at 3.
- Steady state with out_ready_i=1: one packet per cycle, PCs consecutive by +8.
- out_ready_i=0: at most 2 packets buffered, then issue stops. Packet fields stay stable while out_valid_o && !out_ready_i.
- Memory contents are read-only to this block and have no latency other than 1 cycle.

## Test plan
- Reset, RESET_PC=10'h000, out_ready_i=1 constantly -> out_valid_o first high 3 cycles after reset release. Packets pc=0x000, 0x008, 0x010… on consecutive cycles, inst0/inst1 match memory words.
- Backpressure: out_ready_i=0 for 6 cycles -> exactly 2 reads issued, packet pc=0x000 held stable. On release -> 0x000, 0x008, 0x010 in order with no gaps or duplicates.
- Redirect to 10'h1A6 mid-stream with out_ready_i=1 -> out_valid_o low for 3 cycles. Next packet pc=0x1A4. No stale packet from before the redirect appears.
- Wrap: redirect to 10'h3F0 -> packets 0x3F0, 0x3F8, 0x000.
- Back-to-back redirects on two consecutive cycles (0x040 then 0x100) -> only pc=0x100 appears, 3 cycles after the second redirect.
- Redirect coincident with an accepted-looking handshake and a pending response -> buffer empty next cycle, first post-redirect packet is the redirect target.
